stopwatch_cmd_ctrl: RTL and testbench
=====================================

# stopwatch_cmd_ctrl

Command front end for the stopwatch core: conditions three raw pushbuttons (start, pause, stop) into clean, arbitrated, single-cycle command pulses. The block sits between the board keys and the stopwatch's `start`/`pause`/`stop` inputs. The core samples those inputs as levels every cycle and would otherwise re-trigger state transitions for as long as a key is held. The block synchronises, debounces, edge-detects, prioritises and rate-limits the commands.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive cycles a synchronised key level must hold before it is accepted (10 ms at 50 MHz); minimum 1.
- GAP_CYCLES, 2500000: lockout length after an issued command, during which new presses are dropped; minimum 1.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- key_start_n  in  1  raw start key, active-low (0 = pressed), asynchronous to clk.
- key_pause_n  in  1  raw pause key, active-low.
- key_stop_n  in  1  raw stop key, active-low.
- start  out  1  one-cycle start command; reset 0.
- pause  out  1  one-cycle pause command; reset 0.
- stop  out  1  one-cycle stop command; reset 0.
- busy  out  1  high while in ISSUE or LOCKOUT; reset 0.
- cmd_dropped  out  1  one-cycle flag when a debounced press is discarded; reset 0.

## Operation
- **Synchroniser.** Each key passes through a 2-FF synchroniser. Both flops reset to 0 (pressed).
- **Debouncer (per key).**
  - The stable level resets to pressed, and the counter resets to 0.
  - If the synchronised level equals the stable level, the counter clears.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, the stable level takes the new value and the counter clears.
  - A key held through reset therefore yields no command until it is released and pressed again.
- **Press event.** Asserted for exactly one cycle when the stable level goes from released to pressed. Release events are ignored.
- **Arbiter FSM, states IDLE, ISSUE, LOCKOUT.** Reset state is IDLE.
  - IDLE: if any press event is present, select the winner by priority stop > pause > start, register the winner's command, and go to ISSUE. Any simultaneous losing events pulse cmd_dropped in the same cycle.
  - ISSUE: exactly one of start/pause/stop is high for one cycle. The lockout counter loads GAP_CYCLES-1. Next state is LOCKOUT.
  - LOCKOUT: the counter decrements. When it reaches 0, the FSM returns to IDLE on the following edge. Any press event in ISSUE or LOCKOUT is discarded with a cmd_dropped pulse.
- **Output guarantees.**
  - Command outputs are mutually exclusive and are never high on two consecutive cycles.
  - Minimum spacing between commands is GAP_CYCLES+1 cycles.
- **Reset mid-operation.** All outputs go to 0 immediately. A pending command is lost.

## Timing
- **Latency with CMD_DEBOUNCE_EN.** A raw key level captured at the first synchroniser at edge k produces a command pulse high after edge k+DEBOUNCE_CYCLES+3, lasting one cycle.
- **Latency without CMD_DEBOUNCE_EN.** The same pulse appears after edge k+3.
- **Glitches.** A glitch shorter than DEBOUNCE_CYCLES cycles, measured at the synchroniser output, produces no event and no cmd_dropped.
- **busy** rises together with the command pulse and falls GAP_CYCLES cycles after the pulse falls.
- **Counter widths.** Counter widths are $clog2 of their parameters. There is no wrap: the counters saturate by construction.

## Configuration
- **`STOPWATCH_CMD_DEBOUNCE_EN` defined:** debounce counters are instantiated, with the behaviour above.
- **`STOPWATCH_CMD_DEBOUNCE_EN` undefined:** the stable level is the synchronised level itself, and DEBOUNCE_CYCLES is ignored. This mode is intended for fast simulation and for pre-debounced inputs. Reset behaviour is unchanged: a key held through reset is not reported.

## Structure
- **Shared package stopwatch_pkg:**
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, LOCKOUT=2'd2.
  - Command index constants: CMD_START=0, CMD_PAUSE=1, CMD_STOP=2.
  - Key pressed level constant (1'b0).
- **Sub-module key_debouncer:** contains the synchroniser, the debounce counter, the stable level and the press-event output. It is instantiated three times in a generate loop. The arbiter FSM and the lockout counter stay in the top module.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, GAP_CYCLES=8, with `STOPWATCH_CMD_DEBOUNCE_EN` defined.
- **Reset with key held.** Hold key_start_n=0 through reset release for 50 cycles → start stays 0, cmd_dropped stays 0.
- **Single press.** Release all keys, then drive key_pause_n 1→0 at edge k and hold → pause=1 only in the cycle after edge k+7, and busy=1 for the following 9 cycles.
- **Glitch rejection.** Pulse key_stop_n low for 3 cycles → no stop pulse, no cmd_dropped.
- **Simultaneous press.** Press start and stop in the same cycle → stop pulses once, cmd_dropped pulses once, start stays 0.
- **Press during lockout.** Press start 3 cycles after a pause command → cmd_dropped=1 for one cycle, no start. A fresh start press after busy falls → start pulse.
- **Reset mid-operation.** Assert rst during LOCKOUT → busy and all outputs are 0 asynchronously. After release with keys idle → FSM is in IDLE, and the next press is issued normally.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch command front end.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam int   NUM_CMDS    = 3;
  localparam int   CMD_START   = 0;
  localparam int   CMD_PAUSE   = 1;
  localparam int   CMD_STOP    = 2;
  localparam logic KEY_PRESSED = 1'b0;

  // Keeps counters at least one bit wide when a parameter is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_cmd_ctrl_if.sv
// Key inputs and command outputs between the board keys and the stopwatch core.
interface stopwatch_cmd_ctrl_if;
  logic key_start_n;
  logic key_pause_n;
  logic key_stop_n;
  logic start;
  logic pause;
  logic stop;
  logic busy;
  logic cmd_dropped;

  modport master (
    output key_start_n, key_pause_n, key_stop_n,
    input  start, pause, stop, busy, cmd_dropped
  );

  modport slave (
    input  key_start_n, key_pause_n, key_stop_n,
    output start, pause, stop, busy, cmd_dropped
  );
endinterface

// File: rtl/key_debouncer.sv
// Per-key synchroniser, debouncer and registered press-event detector.
// Debounce counter present only with STOPWATCH_CMD_DEBOUNCE_EN defined.
module key_debouncer
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  logic sync_1, sync_2, stable, stable_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= KEY_PRESSED;
      sync_2 <= KEY_PRESSED;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
    end
  end

`ifdef STOPWATCH_CMD_DEBOUNCE_EN
  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= KEY_PRESSED;
      cnt    <= '0;
    end else if (sync_2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^DEBOUNCE_CYCLES;
  assign stable     = sync_2;
`endif

  // stable_d resets to pressed so a key held through reset never fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_d <= KEY_PRESSED;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= (stable_d != KEY_PRESSED) && (stable == KEY_PRESSED);
    end
  end

endmodule

// File: rtl/stopwatch_cmd_ctrl.sv
// Stopwatch command front end: debounced keys, priority arbiter, lockout.
// Optional debounce counters controlled by STOPWATCH_CMD_DEBOUNCE_EN.
//
// state   | meaning
// IDLE    | waiting for a press event
// ISSUE   | one command pulse on the outputs, lockout counter loads
// LOCKOUT | counting down the gap, presses dropped
module stopwatch_cmd_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int GAP_CYCLES      = 2500000
) (
  input  logic                  clk,
  input  logic                  rst,
  stopwatch_cmd_ctrl_if.slave   bus
);

  localparam int            GW       = cnt_width(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  logic [NUM_CMDS-1:0] keys_n, press, cmd_q, cmd_next;
  logic [GW-1:0]       gap_cnt, gap_next;
  state_t              state, next_state;
  logic                dropped;

  assign keys_n[CMD_START] = bus.key_start_n;
  assign keys_n[CMD_PAUSE] = bus.key_pause_n;
  assign keys_n[CMD_STOP]  = bus.key_stop_n;

  for (genvar i = 0; i < NUM_CMDS; i++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk   (clk),
      .rst   (rst),
      .key_n (keys_n[i]),
      .press (press[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cmd_q   <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= next_state;
      cmd_q   <= cmd_next;
      gap_cnt <= gap_next;
    end
  end

  always_comb begin
    next_state = state;
    cmd_next   = '0;
    gap_next   = gap_cnt;
    dropped    = 1'b0;
    unique case (state)
      IDLE: begin
        if (press[CMD_STOP])       cmd_next[CMD_STOP]  = 1'b1;
        else if (press[CMD_PAUSE]) cmd_next[CMD_PAUSE] = 1'b1;
        else if (press[CMD_START]) cmd_next[CMD_START] = 1'b1;
        if (|press) next_state = ISSUE;
        dropped = |(press & ~cmd_next);
      end
      ISSUE: begin
        gap_next   = GAP_LOAD;
        next_state = LOCKOUT;
        dropped    = |press;
      end
      LOCKOUT: begin
        dropped = |press;
        if (gap_cnt == '0) next_state = IDLE;
        else               gap_next   = gap_cnt - GW'(1);
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.start       = cmd_q[CMD_START];
  assign bus.pause       = cmd_q[CMD_PAUSE];
  assign bus.stop        = cmd_q[CMD_STOP];
  assign bus.busy        = (state != IDLE);
  assign bus.cmd_dropped = dropped;

endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// Scoreboard bench for stopwatch_cmd_ctrl (DEBOUNCE_CYCLES=4, GAP_CYCLES=8).
module tb_stopwatch_cmd_ctrl;

  localparam int DEB = 4;
  localparam int GAP = 8;
`ifdef STOPWATCH_CMD_DEBOUNCE_EN
  localparam int LAT = DEB + 4;
`else
  localparam int LAT = 4;
`endif
  localparam int EV_START = 0, EV_PAUSE = 1, EV_STOP = 2, EV_DROP = 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b1;
  int   busy_from = -100;
  int   busy_to = -100;
  int   n_start = 0;
  ev_t  sb[$];

  stopwatch_cmd_ctrl_if bus ();

  stopwatch_cmd_ctrl #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    sb.push_back(e);
    if (kind != EV_DROP) begin
      busy_from = at;
      busy_to   = at + GAP;
    end
  endtask

  task automatic got_ev(input int kind);
    ev_t e;
    chk("sb_nonempty", int'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("evt_kind", kind, e.kind);
      chk("evt_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.cmd_dropped) got_ev(EV_DROP);
      if (bus.stop)        got_ev(EV_STOP);
      if (bus.pause)       got_ev(EV_PAUSE);
      if (bus.start) begin
        n_start++;
        got_ev(EV_START);
      end
      chk("busy", int'(bus.busy), int'(cyc >= busy_from && cyc <= busy_to));
    end
  end

  task automatic keys(input logic s, input logic p, input logic t);
    bus.key_start_n = s;
    bus.key_pause_n = p;
    bus.key_stop_n  = t;
  endtask

  initial begin
    keys(1'b0, 1'b1, 1'b1);
    #12;
    chk("rst_start", int'(bus.start), 0);
    chk("rst_pause", int'(bus.pause), 0);
    chk("rst_stop",  int'(bus.stop), 0);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_drop",  int'(bus.cmd_dropped), 0);
    tick(2);
    rst = 1'b1;

    // start held through reset: nothing may appear
    tick(50);
    chk("held_no_start", n_start, 0);
    chk("held_drained", sb.size(), 0);

    // single press
    keys(1'b1, 1'b1, 1'b1);
    tick(30);
    bus.key_pause_n = 1'b0;
    push_ev(EV_PAUSE, cyc + LAT);
    tick(30);
    chk("single_drained", sb.size(), 0);

    // glitch on stop
    keys(1'b1, 1'b1, 1'b1);
    tick(30);
    bus.key_stop_n = 1'b0;
`ifndef STOPWATCH_CMD_DEBOUNCE_EN
    push_ev(EV_STOP, cyc + LAT);
`endif
    tick(3);
    bus.key_stop_n = 1'b1;
    tick(30);
    chk("glitch_drained", sb.size(), 0);

    // simultaneous start and stop
    keys(1'b0, 1'b1, 1'b0);
    push_ev(EV_DROP, cyc + LAT - 1);
    push_ev(EV_STOP, cyc + LAT);
    tick(30);
    chk("simul_drained", sb.size(), 0);

    // start pressed while pause is in lockout, then a fresh start
    keys(1'b1, 1'b1, 1'b1);
    tick(30);
    bus.key_pause_n = 1'b0;
    push_ev(EV_PAUSE, cyc + LAT);
    tick(3);
    bus.key_start_n = 1'b0;
    push_ev(EV_DROP, cyc + LAT - 1);
    tick(30);
    keys(1'b1, 1'b1, 1'b1);
    tick(30);
    bus.key_start_n = 1'b0;
    push_ev(EV_START, cyc + LAT);
    tick(30);
    chk("lockout_drained", sb.size(), 0);
    chk("lockout_starts", n_start, 1);

    // reset during lockout
    keys(1'b1, 1'b1, 1'b1);
    tick(30);
    bus.key_pause_n = 1'b0;
    push_ev(EV_PAUSE, cyc + LAT);
    tick(LAT + 3);
    chk("pre_rst_busy", int'(bus.busy), 1);
    mon_en = 1'b0;
    keys(1'b1, 1'b1, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_busy",  int'(bus.busy), 0);
    chk("arst_start", int'(bus.start), 0);
    chk("arst_pause", int'(bus.pause), 0);
    chk("arst_stop",  int'(bus.stop), 0);
    chk("arst_drop",  int'(bus.cmd_dropped), 0);
    tick(3);
    rst = 1'b1;
    busy_from = -100;
    busy_to   = -100;
    tick(30);
    chk("post_rst_state", int'(dut.state), 0);
    chk("post_rst_busy", int'(bus.busy), 0);
    chk("post_rst_drained", sb.size(), 0);
    mon_en = 1'b1;
    bus.key_start_n = 1'b0;
    push_ev(EV_START, cyc + LAT);
    tick(30);
    chk("final_drained", sb.size(), 0);
    chk("final_starts", n_start, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
